// File: rtl/machina_pkg.sv
// machina_pkg: shared widths for the perceptron and loss stages plus loss error-register states
package machina_pkg;
  localparam int DEF_RES_WIDTH = 8;
  localparam int DEF_ERR_WIDTH = 16;
  localparam int DEF_SUM_WIDTH = 24;
  localparam int DEF_EPOCH = 4;
  localparam int PCP_OUT_WIDTH = DEF_RES_WIDTH;
  localparam int PCP_ERR_WIDTH = DEF_ERR_WIDTH;
  typedef enum logic {ERR_EMPTY, ERR_FULL} err_state_t;
endpackage

// File: rtl/loss_if.sv
// loss_if: result/target join, error stream and epoch-sum stream of the loss stage
interface loss_if import machina_pkg::*; #(
  parameter int RES_WIDTH = DEF_RES_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
);
  logic en;
  logic res_valid, res_ready, tgt_valid, tgt_ready;
  logic [RES_WIDTH-1:0] res_data, tgt_data;
  logic err_valid, err_ready;
  logic [ERR_WIDTH-1:0] err_data;
  logic sum_valid, sum_ready;
  logic [SUM_WIDTH-1:0] sum_data;
  modport slave(
    input en, res_valid, res_data, tgt_valid, tgt_data, err_ready, sum_ready,
    output res_ready, tgt_ready, err_valid, err_data, sum_valid, sum_data
  );
  modport master(
    output en, res_valid, res_data, tgt_valid, tgt_data, err_ready, sum_ready,
    input res_ready, tgt_ready, err_valid, err_data, sum_valid, sum_data
  );
endinterface

// File: rtl/stream_join.sv
// stream_join: two-input valid/ready join; both sides transfer together when accept allows
module stream_join (
  input  logic a_valid,
  input  logic b_valid,
  input  logic accept,
  output logic a_ready,
  output logic b_ready,
  output logic fire
);
  assign a_ready = b_valid && accept;
  assign b_ready = a_valid && accept;
  assign fire = a_valid && b_valid && accept;
endmodule

// File: rtl/loss.sv
// loss: signed training error tgt-res with per-epoch saturating absolute-error sum
module loss import machina_pkg::*; #(
  parameter int RES_WIDTH = DEF_RES_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH,
  parameter int EPOCH = DEF_EPOCH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
  input logic clk,
  input logic rst,
  loss_if.slave bus
);
  localparam int CW = EPOCH > 1 ? $clog2(EPOCH) : 1;
  err_state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [SUM_WIDTH-1:0] acc, sum_q, acc_sat;
  logic [SUM_WIDTH:0] wide;
  logic [ERR_WIDTH-1:0] err_q, e;
  logic [RES_WIDTH-1:0] mag;
  logic sum_v, last, accept, fire;
  assign last = count == CW'(EPOCH - 1);
  // the final pair of an epoch waits only while an untaken sum would be overwritten
  assign accept = (state == ERR_EMPTY || bus.err_ready) && !(last && sum_v && !bus.sum_ready);
  stream_join u_join (
    .a_valid(bus.res_valid),
    .b_valid(bus.tgt_valid),
    .accept (accept),
    .a_ready(bus.res_ready),
    .b_ready(bus.tgt_ready),
    .fire   (fire)
  );
  assign e = {{(ERR_WIDTH-RES_WIDTH){1'b0}}, bus.tgt_data} - {{(ERR_WIDTH-RES_WIDTH){1'b0}}, bus.res_data};
  assign mag = bus.tgt_data >= bus.res_data ? bus.tgt_data - bus.res_data : bus.res_data - bus.tgt_data;
  assign wide = {1'b0, acc} + (SUM_WIDTH+1)'(mag);
  assign acc_sat = wide[SUM_WIDTH] ? '1 : wide[SUM_WIDTH-1:0];
  // error register: a new pair with en reloads, otherwise a taken error empties it
  always_comb state_nxt = fire && bus.en ? ERR_FULL : (bus.err_ready ? ERR_EMPTY : state);
  // error register state
  always_ff @(posedge clk) state <= rst ? ERR_EMPTY : state_nxt;
  // error payload, held while pending even if en drops
  always_ff @(posedge clk)
    if (rst) err_q <= '0;
    else if (fire && bus.en) err_q <= e;
  // epoch accumulator and sum output; a pending sum may be replaced in the edge it is taken
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      count <= '0;
      sum_v <= 1'b0;
      sum_q <= '0;
    end else begin
      if (fire) begin
        acc <= last ? '0 : acc_sat;
        count <= last ? '0 : count + CW'(1);
      end
      if (fire && last) begin
        sum_v <= 1'b1;
        sum_q <= acc_sat;
      end else if (bus.sum_ready) sum_v <= 1'b0;
    end
  assign bus.err_valid = state == ERR_FULL;
  assign bus.err_data = err_q;
  assign bus.sum_valid = sum_v;
  assign bus.sum_data = sum_q;
endmodule

// File: tb/tb_loss.sv
// tb_loss: directed vectors, corner sequences and a randomized scoreboard for loss
module tb_loss;
  localparam int EP = 4;
  localparam int SMAX = 2**24 - 1;
  typedef struct {
    bit rs;
    logic [7:0] t, r;
    logic [15:0] e;
    bit sv;
    logic [23:0] s;
  } vec_t;
  logic clk = 0, rst_m = 1, rst_s = 1, rst_o = 1;
  int tests = 0, fails = 0;
  logic [15:0] q_err[$];
  logic [23:0] q_sum[$];
  int macc = 0, mcnt = 0;
  bit fired = 0;
  vec_t tv[6];
  logic [7:0] inf[4];
  loss_if m ();
  loss_if #(.SUM_WIDTH(8)) s ();
  loss_if o ();
  loss u_m (.clk(clk), .rst(rst_m), .bus(m));
  loss #(.SUM_WIDTH(8)) u_s (.clk(clk), .rst(rst_s), .bus(s));
  loss #(.EPOCH(1)) u_o (.clk(clk), .rst(rst_o), .bus(o));
  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_main();
    rst_m = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_m = 0;
  endtask

  task automatic pair(input logic [7:0] t, input logic [7:0] r);
    m.tgt_data = t;
    m.res_data = r;
    m.res_valid = 1;
    m.tgt_valid = 1;
    #1;
    for (int i = 0; i < 50 && !m.res_ready; i++) cyc();
    chk("pair_ready", 32'(m.res_ready), 1);
    cyc();
    m.res_valid = 0;
    m.tgt_valid = 0;
  endtask

  task automatic rand_cycle(input bit drain);
    logic [15:0] ee;
    logic [23:0] se;
    bit ev, sv, rdy;
    int d;
    if (drain) begin
      m.res_valid = 0;
      m.tgt_valid = 0;
      m.err_ready = 1;
      m.sum_ready = 1;
    end else begin
      if (fired || !m.res_valid) begin
        m.res_valid = $urandom_range(0, 3) != 0;
        m.res_data = 8'($urandom);
      end
      if (fired || !m.tgt_valid) begin
        m.tgt_valid = $urandom_range(0, 3) != 0;
        m.tgt_data = 8'($urandom);
      end
      m.en = $urandom_range(0, 3) != 0;
      m.err_ready = $urandom_range(0, 3) != 0;
      m.sum_ready = $urandom_range(0, 2) == 0;
    end
    @(negedge clk);
    ev = q_err.size() != 0;
    sv = q_sum.size() != 0;
    chk("rand_err_valid", 32'(m.err_valid), 32'(ev));
    chk("rand_sum_valid", 32'(m.sum_valid), 32'(sv));
    rdy = (!ev || m.err_ready) && !(mcnt == EP - 1 && sv && !m.sum_ready);
    chk("rand_res_ready", 32'(m.res_ready), 32'(m.tgt_valid && rdy));
    chk("rand_tgt_ready", 32'(m.tgt_ready), 32'(m.res_valid && rdy));
    if (ev && m.err_ready) begin
      ee = q_err.pop_front();
      chk("rand_err_data", 32'(m.err_data), 32'(ee));
    end
    if (sv && m.sum_ready) begin
      se = q_sum.pop_front();
      chk("rand_sum_data", 32'(m.sum_data), 32'(se));
    end
    fired = m.res_valid && m.tgt_valid && rdy;
    if (fired) begin
      d = int'(m.tgt_data) - int'(m.res_data);
      if (m.en) q_err.push_back(16'(d));
      macc += d < 0 ? -d : d;
      if (macc > SMAX) macc = SMAX;
      mcnt++;
      if (mcnt == EP) begin
        q_sum.push_back(24'(macc));
        macc = 0;
        mcnt = 0;
      end
    end
    cyc();
  endtask

  initial begin
    tv[0] = '{1, 8'hff, 8'h00, 16'h00ff, 0, 24'd0};
    tv[1] = '{0, 8'h00, 8'hff, 16'hff01, 0, 24'd0};
    tv[2] = '{1, 8'h14, 8'h0a, 16'h000a, 0, 24'd0};
    tv[3] = '{0, 8'h0a, 8'h1e, 16'hffec, 0, 24'd0};
    tv[4] = '{0, 8'h37, 8'h37, 16'h0000, 0, 24'd0};
    tv[5] = '{0, 8'h05, 8'h00, 16'h0005, 1, 24'd35};
    inf = '{8'h00, 8'h00, 8'h00, 8'hff};
    {m.en, m.res_valid, m.tgt_valid, m.err_ready, m.sum_ready} = '0;
    {s.en, s.res_valid, s.tgt_valid, s.err_ready, s.sum_ready} = '0;
    {o.en, o.res_valid, o.tgt_valid, o.err_ready, o.sum_ready} = '0;
    m.res_data = 0; m.tgt_data = 0; s.res_data = 0; s.tgt_data = 0; o.res_data = 0; o.tgt_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_m = 0; rst_s = 0; rst_o = 0;
    chk("rst_err_valid", 32'(m.err_valid), 0);
    chk("rst_sum_valid", 32'(m.sum_valid), 0);
    chk("rst_res_ready", 32'(m.res_ready), 0);
    chk("rst_tgt_ready", 32'(m.tgt_ready), 0);
    chk("rst_err_data", 32'(m.err_data), 0);
    chk("rst_sum_data", 32'(m.sum_data), 0);
    m.res_valid = 1;
    #1;
    chk("rst_res_ready_no_tgt", 32'(m.res_ready), 0);
    m.res_valid = 0;
    cyc();
    m.en = 1; m.err_ready = 1; m.sum_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (tv[i].rs) begin
        rst_main();
        chk("vec_err_idle", 32'(m.err_valid), 0);
      end
      pair(tv[i].t, tv[i].r);
      chk("vec_err_valid", 32'(m.err_valid), 1);
      chk("vec_err_data", 32'(m.err_data), 32'(tv[i].e));
      chk("vec_sum_valid", 32'(m.sum_valid), 32'(tv[i].sv));
      if (tv[i].sv) chk("vec_sum_data", 32'(m.sum_data), 32'(tv[i].s));
    end
    pair(8'h01, 8'h00);
    pair(8'h00, 8'h02);
    pair(8'h03, 8'h00);
    m.tgt_data = 8'h04; m.res_data = 8'h00; m.res_valid = 1; m.tgt_valid = 1;
    repeat (3) begin
      #1;
      chk("stall_res_ready", 32'(m.res_ready), 0);
      chk("stall_sum_hold", 32'(m.sum_data), 35);
      cyc();
    end
    m.sum_ready = 1;
    #1;
    chk("stall_release_ready", 32'(m.res_ready), 1);
    cyc();
    m.res_valid = 0; m.tgt_valid = 0;
    chk("swap_sum_valid", 32'(m.sum_valid), 1);
    chk("swap_sum_data", 32'(m.sum_data), 10);
    chk("swap_err_data", 32'(m.err_data), 32'h0004);
    cyc();
    chk("swap_sum_clear", 32'(m.sum_valid), 0);
    rst_main();
    m.en = 1; m.err_ready = 0; m.sum_ready = 1;
    pair(8'h30, 8'h10);
    chk("bp_err_data", 32'(m.err_data), 32'h0020);
    m.tgt_data = 8'h05; m.res_data = 8'h08; m.res_valid = 1; m.tgt_valid = 1;
    m.en = 0;
    repeat (5) begin
      #1;
      chk("bp_res_ready", 32'(m.res_ready), 0);
      chk("bp_tgt_ready", 32'(m.tgt_ready), 0);
      chk("bp_err_valid", 32'(m.err_valid), 1);
      chk("bp_err_stable", 32'(m.err_data), 32'h0020);
      cyc();
    end
    m.en = 1; m.err_ready = 1;
    pair(8'h05, 8'h08);
    chk("bp_second", 32'(m.err_data), 32'hfffd);
    pair(8'h09, 8'h01);
    chk("bp_third", 32'(m.err_data), 32'h0008);
    chk("bp_third_valid", 32'(m.err_valid), 1);
    cyc();
    chk("bp_drained", 32'(m.err_valid), 0);
    rst_main();
    m.en = 0; m.err_ready = 0; m.sum_ready = 0;
    for (int i = 0; i < 4; i++) begin
      m.tgt_data = inf[i]; m.res_data = inf[i]; m.res_valid = 1; m.tgt_valid = 1;
      #1;
      chk("inf_ready", 32'(m.res_ready), 1);
      cyc();
      chk("inf_no_err", 32'(m.err_valid), 0);
    end
    m.res_valid = 0; m.tgt_valid = 0;
    chk("inf_sum_valid", 32'(m.sum_valid), 1);
    chk("inf_sum_data", 32'(m.sum_data), 0);
    rst_main();
    m.en = 1; m.err_ready = 1; m.sum_ready = 0;
    pair(8'h09, 8'h00);
    pair(8'h00, 8'h09);
    rst_m = 1;
    cyc();
    rst_m = 0;
    chk("mid_rst_err", 32'(m.err_valid), 0);
    chk("mid_rst_sum", 32'(m.sum_valid), 0);
    repeat (4) pair(8'h01, 8'h00);
    chk("mid_rst_sum_valid", 32'(m.sum_valid), 1);
    chk("mid_rst_sum_data", 32'(m.sum_data), 4);
    s.en = 1; s.err_ready = 1; s.sum_ready = 0;
    s.tgt_data = 8'hff; s.res_data = 8'h00; s.res_valid = 1; s.tgt_valid = 1;
    repeat (4) cyc();
    s.res_valid = 0; s.tgt_valid = 0;
    chk("sat_sum_valid", 32'(s.sum_valid), 1);
    chk("sat_sum_data", 32'(s.sum_data), 255);
    chk("sat_err_data", 32'(s.err_data), 32'h00ff);
    o.en = 1; o.err_ready = 1; o.sum_ready = 1;
    o.res_valid = 1; o.tgt_valid = 1;
    o.tgt_data = 8'h07; o.res_data = 8'h02;
    cyc();
    chk("ep1_sum_a", 32'(o.sum_data), 5);
    o.tgt_data = 8'h00; o.res_data = 8'hc8;
    cyc();
    chk("ep1_sum_b", 32'(o.sum_data), 200);
    chk("ep1_valid_b", 32'(o.sum_valid), 1);
    o.tgt_data = 8'hff; o.res_data = 8'h00;
    cyc();
    o.res_valid = 0; o.tgt_valid = 0;
    chk("ep1_sum_c", 32'(o.sum_data), 255);
    rst_main();
    fired = 0; macc = 0; mcnt = 0;
    q_err.delete();
    q_sum.delete();
    repeat (3000) rand_cycle(0);
    repeat (6) rand_cycle(1);
    chk("rand_drain_err", 32'(m.err_valid), 0);
    chk("rand_drain_sum", 32'(m.sum_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/loss.md
# loss

Training error stage directly downstream of `perceptron`. It pairs each forward result with its target sample and computes the signed error `tgt - res`. The error is streamed back to the perceptron's backward (error) input. Absolute error is accumulated per epoch and reported as a summary stream, which benches and the training controller use for convergence checks.

## Interface
- `RES_WIDTH`, default 8: width of unsigned result and target samples.
- `ERR_WIDTH`, default 16: width of signed error output; must be ≥ `RES_WIDTH+1`.
- `EPOCH`, default 4: samples per epoch, ≥ 1.
- `SUM_WIDTH`, default 24: width of the unsigned epoch absolute-error sum.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: training enable; when 0, errors are computed and accumulated but not emitted.
- `res_valid` in 1: result sample valid.
- `res_data` in `RES_WIDTH`: perceptron result.
- `res_ready` out 1: result accepted this cycle.
- `tgt_valid` in 1: target sample valid.
- `tgt_data` in `RES_WIDTH`: target value.
- `tgt_ready` out 1: target accepted this cycle.
- `err_valid` out 1: error sample valid.
- `err_data` out `ERR_WIDTH`: signed error, two's complement.
- `err_ready` in 1: downstream (perceptron backward port) accepts the error.
- `sum_valid` out 1: epoch sum valid.
- `sum_data` out `SUM_WIDTH`: epoch absolute-error sum.
- `sum_ready` in 1: epoch sum accepted.

## Operation
- All streams use a valid/ready handshake. A transfer occurs when valid and ready are both high on a rising edge. A valid signal never depends on its ready. Once valid is raised, data stays stable until the transfer.
- Join: a pair is consumed only when `res_valid && tgt_valid && accept`. In that case `res_ready = tgt_valid && accept` and `tgt_ready = res_valid && accept`; both sides transfer together and never singly.
- `accept = (!err_valid || err_ready) && !(last && sum_valid && !sum_ready)`, where `last = (count == EPOCH-1)`.
- Error: `e = $signed({1'b0,tgt}) - $signed({1'b0,res})`, sign-extended to `ERR_WIDTH`. Range is ±(2^RES_WIDTH − 1) and never overflows.
- Error register has two states:
  - EMPTY → FULL on a pair consumed with `en=1`.
  - FULL → EMPTY on `err_ready` with no new pair.
  - FULL → FULL (reloaded) on `err_ready` together with a new pair.
- If `en=0`, consumed pairs do not load the error register. A pending error already in the register is held until it is accepted; it is never dropped on an `en` change.
- Accumulator: on every consumed pair, `acc += |e|`, saturating at 2^SUM_WIDTH − 1. `count` increments.
- On the consumed pair where `last` holds:
  - `sum_data` loads the saturated `acc + |e|` and `sum_valid` is set.
  - `acc` and `count` clear.
- `sum_valid` clears on `sum_ready`. A new epoch may accumulate while the sum is pending. The final pair of that next epoch stalls until the pending sum is accepted.

## Timing
- Reset values: `err_valid=0`, `err_data=0`, `sum_valid=0`, `sum_data=0`, `acc=0`, `count=0`. `res_ready` and `tgt_ready` follow the combinational rule above and are 0 whenever the opposite valid is 0.
- `rst` mid-operation discards the pending error, the pending sum and the partial epoch. No output is produced for the partial epoch.
- Latency: `err_valid`/`err_data` appear one cycle after the pair handshake. `sum_valid` appears one cycle after the last pair of the epoch.
- Throughput: one pair per cycle while `err_ready=1` (or `en=0`) and the sum is not blocking.
- `EPOCH=1`: every pair produces a sum equal to its own |e|.
- Simultaneous `sum_ready` and a last-pair arrival: the old sum transfers and the new sum loads in the same edge, with no bubble.

## Structure
- `RES_WIDTH`, `ERR_WIDTH` and `SUM_WIDTH` defaults come from the shared package `machina_pkg`, alongside the perceptron's width constants, so both stages agree.
- Sub-module `stream_join` generates the two-input valid/ready join with `accept` as an input. It is reusable for argument collection.
- The saturating accumulator and error register stay inline.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all inputs idle → `err_valid=0`, `sum_valid=0`, `res_ready=0`, `tgt_ready=0`.
- **Sign and latency:** with `en=1` and `err_ready=1`, drive tgt=0xff/res=0x00, then tgt=0x00/res=0xff.
  - Errors are `0x00FF` then `0xFF01`, each one cycle after its handshake.
- **Back-pressure:** hold `err_ready=0` for 5 cycles with pairs offered.
  - `err_data` is stable and both readies are 0.
  - On release, all pairs arrive in order with none lost or duplicated.
- **Epoch sum (`EPOCH=4`):** drive errors +10, −20, 0, +5 → `sum_data=35`.
  - `sum_valid` rises one cycle after the 4th handshake, and the next epoch restarts from 0.
  - With `sum_ready=0`, the 8th pair stalls until the sum is taken.
- **Inference mode:** `en=0` with AND-gate targets 00, 00, 00, ff and exactly matching results.
  - Pairs are consumed one per cycle, `err_valid` stays 0, and `sum_data=0`.
- **Saturation and mid-reset:**
  - With `SUM_WIDTH=8`, four errors of 255 → `sum_data=255`.
  - Two pairs, then `rst`, then four pairs of |e|=1 → `sum_data=4`.
